// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for the serial front-end stages.
// Holds the serializer state encoding and the default word width used by the
// serializer and future deserializer and counter stages.
package serial_pkg;
  typedef enum logic {IDLE, SHIFT} ser_state_t;
  localparam int SER_WIDTH = 8;
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end feeding the sequence detector.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   data_in    WIDTH-bit word, sampled only on accept edges
//   load_valid data_in is valid
//   load_ready a word can be accepted this cycle (0 while in reset)
//   X          serial bit, IDLE_BIT when nothing is shifting
//   x_valid    X carries a data bit
//   last       X is the final bit of the current word
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             X,
  output logic             x_valid,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  ser_state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, hold_q, hold_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic hold_full_q, hold_full_d;
  logic accept;
  assign x_valid    = state_q == SHIFT;
  assign last       = x_valid && bitcnt_q == LAST_CNT;
  assign X          = x_valid ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_BIT;
  assign load_ready = rst && (!x_valid || !hold_full_q);
  assign accept     = load_valid && load_ready;
  // The end-of-word edge prefers the held word, then a same-edge bypass, so
  // consecutive words stream with no idle gap.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (state_q == IDLE) begin
      if (accept) begin
        shreg_d  = data_in;
        bitcnt_d = '0;
        state_d  = SHIFT;
      end
    end else if (!last) begin
      shreg_d  = MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
      bitcnt_d = bitcnt_q + 1'b1;
      if (accept) begin
        hold_d      = data_in;
        hold_full_d = 1'b1;
      end
    end else if (hold_full_q) begin
      shreg_d     = hold_q;
      hold_full_d = 1'b0;
      bitcnt_d    = '0;
    end else if (accept) begin
      shreg_d  = data_in;
      bitcnt_d = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: randomized and directed checks of bit_serializer against a bit-queue model.
module tb_bit_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0;
  logic       load_valid = 1'b0;
  logic       ready_m, x_m, xv_m, last_m;
  logic       ready_l, x_l, xv_l, last_l;
  int n_tests = 0;
  int n_fail = 0;
  bit cm[$];
  bit cl[$];
  logic [7:0] pend[$];
  bit acc;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_m), .X(x_m), .x_valid(xv_m), .last(last_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_l), .X(x_l), .x_valid(xv_l), .last(last_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // A word becomes a list of bits in transmission order for each instance.
  task automatic load_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      cm.push_back(w[7-i]);
      cl.push_back(w[i]);
    end
  endtask

  // One clock: drive inputs after the falling edge, check outputs, then
  // advance the model on the rising edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    bit exp_ready;
    @(negedge clk);
    rst = r;
    load_valid = v;
    data_in = d;
    if (!r) begin
      cm.delete();
      cl.delete();
      pend.delete();
    end
    #1;
    exp_ready = r && pend.size() == 0;
    chk("m_ready", ready_m, exp_ready);
    chk("m_xvalid", xv_m, cm.size() != 0);
    chk("m_x", x_m, cm.size() != 0 ? cm[0] : 1'b0);
    chk("m_last", last_m, cm.size() == 1);
    chk("l_ready", ready_l, exp_ready);
    chk("l_xvalid", xv_l, cl.size() != 0);
    chk("l_x", x_l, cl.size() != 0 ? cl[0] : 1'b0);
    chk("l_last", last_l, cl.size() == 1);
    acc = v && exp_ready;
    @(posedge clk);
    if (r) begin
      if (cm.size() != 0) begin
        void'(cm.pop_front());
        void'(cl.pop_front());
      end
      if (cm.size() == 0) begin
        if (pend.size() != 0) load_word(pend.pop_front());
        else if (acc) load_word(d);
      end else if (acc) begin
        pend.push_back(d);
      end
    end
  endtask

  task automatic send(input logic [7:0] w);
    int budget = 40;
    do begin
      step(1'b1, 1'b1, w);
      budget--;
    end while (!acc && budget > 0);
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'($urandom));
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h55);
    idle(1);
    send(8'hB4);
    idle(10);
    send(8'hA5);
    send(8'h3C);
    idle(20);
    send(8'hFF);
    budget = 20;
    while (cm.size() != 1 && budget > 0) begin
      idle(1);
      budget--;
    end
    chk("bypass_reach_last", cm.size(), 1);
    step(1'b1, 1'b1, 8'h0F);
    chk("bypass_accepted", acc, 1'b1);
    chk("bypass_no_hold", ready_m, 1'b1);
    idle(10);
    send(8'hA5);
    idle(2);
    send(8'h3C);
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'h3C);
    send(8'hFF);
    idle(12);
    send(8'h01);
    idle(10);
    for (int i = 0; i < 600; i++) begin
      logic r;
      r = ($urandom_range(0, 99) != 0);
      step(r, ($urandom_range(0, 2) != 0), 8'($urandom));
    end
    idle(12);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the bit-stream sequence detector (`state_machine`). Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `X`, which drives the detector's `X` input directly. A one-word holding buffer lets consecutive words stream with no idle gap between them.

## Interface
- `WIDTH`, 8: word width in bits, ≥2.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, 0: value driven on `X` when no word is shifting.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `data_in`  in  WIDTH  word to serialize.
- `load_valid`  in  1  `data_in` is valid.
- `load_ready`  out  1  block can accept a word this cycle.
- `X`  out  1  serial bit (to detector `X`).
- `x_valid`  out  1  `X` carries a data bit.
- `last`  out  1  `X` is the final bit of the current word.

## Operation
- Registers:
  - `state` (IDLE/SHIFT).
  - `shreg[WIDTH]`.
  - `bitcnt[$clog2(WIDTH)]`.
  - `hold[WIDTH]`.
  - `hold_full`.
- Accept occurs on a rising edge when `load_valid && load_ready`.
- IDLE:
  - `X=IDLE_BIT`, `x_valid=0`, `last=0`, `load_ready=1`.
  - On accept: `shreg<=data_in`, `bitcnt<=0`, go to SHIFT.
- SHIFT:
  - `X` is the head of `shreg` (MSB or LSB per `MSB_FIRST`); `x_valid=1`.
  - `last = (bitcnt==WIDTH-1)`.
  - `load_ready = !hold_full`. An accept loads `hold` and sets `hold_full`.
  - Not last: shift `shreg` toward the head; `bitcnt++`.
- End of word (edge at which `last=1`):
  - If `hold_full`: `shreg<=hold`, `hold_full<=0`, `bitcnt<=0`, stay in SHIFT.
  - Else if accept on this edge: bypass, `shreg<=data_in`, `bitcnt<=0`, stay in SHIFT. `hold` is not written.
  - Else: go to IDLE.
- An accept can occur while `hold_full=1` only if `load_ready=1`. This cannot happen, so no word is ever dropped.
- Outputs come from registered state only. There is no combinational path from `data_in` to `X`.

## Timing
- Reset (`rst=0`, asynchronous):
  - `state=IDLE`, `hold_full=0`, `bitcnt=0`, `shreg=0`.
  - `X=IDLE_BIT`, `x_valid=0`, `last=0`.
  - `load_ready=0` while `rst=0`.
  - The first accept is possible on the first edge after release.
- Latency: a word accepted at edge N drives its first bit in cycle N+1 and its last bit in cycle N+WIDTH.
- Throughput: one bit per clock. Back-to-back words have zero gap when the next word is held, or is bypassed on the last-bit edge.
- `load_ready` deasserts the cycle after `hold` fills. It reasserts the cycle after `hold` is transferred into `shreg`.
- Reset mid-word aborts the word. The partial word and `hold` are discarded; nothing resumes after release.
- `data_in` is sampled only on accept edges; it is don't-care otherwise.

## Structure
- Shared package `serial_pkg`:
  - `typedef enum logic {IDLE, SHIFT} ser_state_t`.
  - Default `WIDTH` constant, shared with future deserializer and counter stages.
- Single module; no sub-module.
  - Shift register, counter and holding buffer are each a few lines and are tightly coupled through the end-of-word decision.

## Test plan
All scenarios use WIDTH=8 and IDLE_BIT=0; MSB_FIRST=1 unless stated.
- Reset:
  - Stimulus: hold `rst=0` with `load_valid=1`, then release.
  - Required: during reset `X=0`, `x_valid=0`, `last=0`, `load_ready=0`; `load_ready=1` in the first cycle after release.
- Single word:
  - Stimulus: accept `8'hB4` at edge N.
  - Required: cycles N+1..N+8 give `X` = 1,0,1,1,0,1,0,0 with `x_valid=1`; `last=1` only at N+8; N+9 has `x_valid=0`, `X=0`.
- Held back-to-back:
  - Stimulus: `8'hA5` then `8'h3C` with `load_valid` held high.
  - Required: 16 contiguous valid bits 10100101 00111100; `load_ready=0` from the cycle after the second accept until the transfer at the end of the first word.
- Bypass:
  - Stimulus: present `8'h0F` only during the last-bit cycle of `8'hFF`.
  - Required: accepted; next cycle `X=0` with `x_valid=1`, i.e. no gap; `hold_full` stays 0.
- Mid-word reset:
  - Stimulus: assert reset after 3 bits of `8'hA5`, with `8'h3C` held; then accept `8'hFF`.
  - Required: outputs idle immediately; after release `8'hFF` yields exactly 8 ones; the `8'h3C` bits never appear.
- LSB-first:
  - Stimulus: MSB_FIRST=0, accept `8'h01`.
  - Required: `X` = 1 then seven 0s; `last` on the eighth bit.
